get_code: RTL and testbench

//  Morse-code symbol collector and letter decoder for the keyer front end.
//  - Accumulates dot/dash key presses into a shift register.
//  - On a send press, decodes the pattern into a 5-bit letter code (A=1..Z=26).
//  - Sits between the debounced push-button inputs and the character display/transmit logic.

---
 rtl/get_code.sv | 102 ++++++++++
 tb/tb_get_code.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/get_code.sv
// Morse symbol collector and letter decoder (A=1..Z=26, 0 = none/invalid).
// Ports: dot/dash/send keys, sync active-high reset, clk; code, temp outputs.
// Optional GETCODE_OVERFLOW_EN: a fifth symbol sets a sticky flag, send gives 31.
module get_code (
  input  logic       dot,
  input  logic       dash,
  input  logic       send,
  input  logic       reset,
  input  logic       clk,
  output logic [4:0] code,
  output logic [4:0] temp
);

  logic       dot_q;
  logic       dash_q;
  logic       send_q;
  // keys held through reset stay masked until released once
  logic [2:0] hold;
`ifdef GETCODE_OVERFLOW_EN
  logic       ovf;
`endif

  logic dot_ev;
  logic dash_ev;
  logic send_ev;

  assign dot_ev  = dot  & ~dot_q  & ~hold[2];
  assign dash_ev = dash & ~dash_q & ~hold[1];
  assign send_ev = send & ~send_q & ~hold[0];

  // temp: leading-1 sentinel, newest symbol in LSB, 1 = dash
  function automatic logic [4:0] decode(input logic [4:0] t);
    logic [4:0] c;
    case (t)
      5'b00010: c = 5'd5;
      5'b00011: c = 5'd20;
      5'b00100: c = 5'd9;
      5'b00101: c = 5'd1;
      5'b00110: c = 5'd14;
      5'b00111: c = 5'd13;
      5'b01000: c = 5'd19;
      5'b01001: c = 5'd21;
      5'b01010: c = 5'd18;
      5'b01011: c = 5'd23;
      5'b01100: c = 5'd4;
      5'b01101: c = 5'd11;
      5'b01110: c = 5'd7;
      5'b01111: c = 5'd15;
      5'b10000: c = 5'd8;
      5'b10001: c = 5'd22;
      5'b10010: c = 5'd6;
      5'b10100: c = 5'd12;
      5'b10110: c = 5'd16;
      5'b10111: c = 5'd10;
      5'b11000: c = 5'd2;
      5'b11001: c = 5'd24;
      5'b11010: c = 5'd3;
      5'b11011: c = 5'd25;
      5'b11100: c = 5'd26;
      5'b11101: c = 5'd17;
      default:  c = 5'd0;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      dot_q  <= 1'b0;
      dash_q <= 1'b0;
      send_q <= 1'b0;
      hold   <= {dot, dash, send};
      code   <= 5'd0;
      temp   <= 5'b00001;
`ifdef GETCODE_OVERFLOW_EN
      ovf    <= 1'b0;
`endif
    end else begin
      dot_q  <= dot;
      dash_q <= dash;
      send_q <= send;
      hold   <= hold & {dot, dash, send};
      if (send_ev) begin
`ifdef GETCODE_OVERFLOW_EN
        code <= ovf ? 5'd31 : decode(temp);
        ovf  <= 1'b0;
`else
        code <= decode(temp);
`endif
        temp <= 5'b00001;
      end else if (dot_ev ^ dash_ev) begin
        if (!temp[4]) begin
          temp <= {temp[3:0], dash_ev};
        end else begin
`ifdef GETCODE_OVERFLOW_EN
          ovf <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_get_code.sv
// Randomized and directed bench for get_code against a symbol-string model.
// Model keeps symbols as a queue and decodes by looking up Morse strings.
module tb_get_code;

  logic       clk = 1'b0;
  logic       reset;
  logic       dot;
  logic       dash;
  logic       send;
  logic [4:0] code;
  logic [4:0] temp;

  int vectors = 0;
  int errors  = 0;

  get_code dut (
    .dot  (dot),
    .dash (dash),
    .send (send),
    .reset(reset),
    .clk  (clk),
    .code (code),
    .temp (temp)
  );

  always #5 clk = ~clk;

  string morse [26] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
    ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
    "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

  bit         mq[$];
  bit         m_ovf;
  logic [4:0] m_code;
  bit         p_dot, p_dash, p_send;
  bit         h_dot, h_dash, h_send;

  task automatic chk(input string tag, input logic [4:0] obs,
                     input logic [4:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (%b) want %0d (%b) at %0t",
               tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic logic [4:0] m_decode();
    string s;
    s = "";
    foreach (mq[i]) s = {s, mq[i] ? "-" : "."};
    for (int i = 0; i < 26; i++)
      if (morse[i] == s) return 5'(i + 1);
    return 5'd0;
  endfunction

  function automatic logic [4:0] m_temp();
    logic [4:0] t;
    t = 5'd1;
    foreach (mq[i]) t = {t[3:0], mq[i]};
    return t;
  endfunction

  task automatic model(input bit d, input bit a, input bit s, input bit r);
    bit de, ae, se;
    if (r) begin
      mq.delete();
      m_ovf  = 0;
      m_code = 5'd0;
      p_dot = 0; p_dash = 0; p_send = 0;
      h_dot = d; h_dash = a; h_send = s;
      return;
    end
    de = d && !p_dot  && !h_dot;
    ae = a && !p_dash && !h_dash;
    se = s && !p_send && !h_send;
    if (se) begin
`ifdef GETCODE_OVERFLOW_EN
      m_code = m_ovf ? 5'd31 : m_decode();
`else
      m_code = m_decode();
`endif
      mq.delete();
      m_ovf = 0;
    end else if (de != ae) begin
      if (mq.size() < 4) mq.push_back(ae);
      else m_ovf = 1;
    end
    p_dot = d; p_dash = a; p_send = s;
    h_dot = h_dot && d; h_dash = h_dash && a; h_send = h_send && s;
  endtask

  task automatic step(input bit d, input bit a, input bit s, input bit r);
    @(negedge clk);
    dot = d; dash = a; send = s; reset = r;
    @(posedge clk);
    model(d, a, s, r);
    #1;
    chk("code", code, m_code);
    chk("temp", temp, m_temp());
  endtask

  // k: 0 dot, 1 dash, 2 send
  task automatic press(input int k);
    step(k == 0, k == 1, k == 2, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic word(input string w);
    for (int i = 0; i < w.len(); i++)
      press(w[i] == "-" ? 1 : 0);
    press(2);
  endtask

  initial begin
    dot = 0; dash = 0; send = 0; reset = 1;
    step(0, 0, 0, 1);
    chk("rst_code", code, 5'd0);
    chk("rst_temp", temp, 5'b00001);

    step(1, 0, 0, 0);
    chk("e_temp", temp, 5'b00010);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("e_code", code, 5'd5);
    chk("e_clr", temp, 5'b00001);
    step(0, 0, 0, 0);

    word("-");    chk("t", code, 5'd20);
    word("..");   chk("i", code, 5'd9);
    word("...");  chk("s", code, 5'd19);
    word("...-"); chk("v", code, 5'd22);
    word("--.-"); chk("q", code, 5'd17);
    word("-.--"); chk("y", code, 5'd25);
    word("..--"); chk("bad", code, 5'd0);
    word("");     chk("empty", code, 5'd0);

    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    chk("held", temp, 5'b00010);
    step(0, 0, 0, 0);
    press(2);
    chk("held_code", code, 5'd5);

    press(0); press(1);
    chk("pre_rst", temp, 5'b00101);
    step(0, 0, 0, 1);
    press(2);
    chk("rst_mid", code, 5'd0);
    chk("rst_mid_t", temp, 5'b00001);

    step(1, 1, 0, 0);
    chk("both", temp, 5'b00001);
    step(0, 0, 0, 0);
    press(0);
    step(0, 1, 1, 0);
    chk("send_win", code, 5'd5);
    step(0, 0, 0, 0);

    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("held_rst", temp, 5'b00001);
    step(0, 0, 0, 0);
    press(0);
    chk("rearm", temp, 5'b00010);
    press(2);

    word(".....");
`ifdef GETCODE_OVERFLOW_EN
    chk("ovf", code, 5'd31);
`else
    chk("trunc", code, 5'd8);
`endif

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 150) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
